markov_table_arbiter: RTL and testbench

- Shares the single-port Markov transition-count table RAM between two requesters: the learner (read-modify-write of counts, appends of new entries) and the sequence generator (read-only lookups).
- Round-robin arbitration, plus a lock so a learner read-increment-write completes atomically.
- Sits between the learner FSM, the generator FSM and the table RAM. The RAM has 1-cycle read latency.

---
 rtl/markov_table_arbiter.sv | 122 ++++++++++++
 tb/tb_markov_table_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/markov_table_arbiter.sv
// Markov table arbiter: shares the single-port transition-count RAM between
// the learner (read/write, with an optional lock for read-increment-write)
// and the sequence generator (read-only). Round-robin when both request.
// A lock that sits idle for LOCK_MAX cycles is forcibly released.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   learn_req/we/lock/addr/wdata  learner request side
//   learn_gnt                  learner access accepted this cycle
//   learn_rvalid/rdata         learner read return (cycle after read grant)
//   gen_req/addr               generator read request
//   gen_gnt                    generator access accepted this cycle
//   gen_rvalid/rdata           generator read return (cycle after grant)
//   mem_en/we/addr/wdata       RAM command (1-cycle read latency)
//   mem_rdata                  RAM read data
//   lock_err                   one-cycle pulse when a lock times out
module markov_table_arbiter #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              learn_req,
  input  logic              learn_we,
  input  logic              learn_lock,
  input  logic [ADDR_W-1:0] learn_addr,
  input  logic [DATA_W-1:0] learn_wdata,
  output logic              learn_gnt,
  output logic              learn_rvalid,
  output logic [DATA_W-1:0] learn_rdata,
  input  logic              gen_req,
  input  logic [ADDR_W-1:0] gen_addr,
  output logic              gen_gnt,
  output logic              gen_rvalid,
  output logic [DATA_W-1:0] gen_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);

  localparam int unsigned CntW = $clog2(LOCK_MAX) + 1;

  typedef enum logic {StArb, StLocked} state_e;

  state_e          state;
  logic            prio;      // 0 = learner wins contention, 1 = generator
  logic [CntW-1:0] lock_cnt;
  logic            lock_timeout;

  always_comb begin
    learn_gnt = 1'b0;
    gen_gnt   = 1'b0;
    if (!reset) begin
      if (state == StLocked) begin
        learn_gnt = learn_req;
      end else begin
        learn_gnt = learn_req & (~gen_req | ~prio);
        gen_gnt   = gen_req & (~learn_req | prio);
      end
    end
  end

  // Forced release is decided in the last idle cycle of the lock window.
  assign lock_timeout = !reset && (state == StLocked) && !learn_req &&
                        (lock_cnt == CntW'(LOCK_MAX - 1));
  assign lock_err     = lock_timeout;

  assign mem_en    = learn_gnt | gen_gnt;
  assign mem_we    = learn_gnt & learn_we;
  assign mem_addr  = learn_gnt ? learn_addr : (gen_gnt ? gen_addr : '0);
  assign mem_wdata = learn_gnt ? learn_wdata : '0;

  assign learn_rdata = mem_rdata;
  assign gen_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StArb;
      prio         <= 1'b0;
      lock_cnt     <= '0;
      learn_rvalid <= 1'b0;
      gen_rvalid   <= 1'b0;
    end else begin
      learn_rvalid <= learn_gnt & ~learn_we;
      gen_rvalid   <= gen_gnt;
      unique case (state)
        StArb: begin
          if (learn_gnt) begin
            prio <= 1'b1;
            if (learn_lock) begin
              state    <= StLocked;
              lock_cnt <= '0;
            end
          end else if (gen_gnt) begin
            prio <= 1'b0;
          end
        end
        StLocked: begin
          if (learn_gnt) begin
            lock_cnt <= '0;
            if (!learn_lock) begin
              state <= StArb;
              prio  <= 1'b1;
            end
          end else if (lock_timeout) begin
            state    <= StArb;
            prio     <= 1'b1;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_markov_table_arbiter.sv
// Directed bench for markov_table_arbiter with a behavioural 1-cycle RAM.
// Read returns are checked by a scoreboard monitor on the falling edge.
module tb_markov_table_arbiter;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
  localparam int LOCK_MAX = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              learn_req = 1'b0, learn_we = 1'b0, learn_lock = 1'b0;
  logic [ADDR_W-1:0] learn_addr = '0;
  logic [DATA_W-1:0] learn_wdata = '0;
  logic              learn_gnt, learn_rvalid;
  logic [DATA_W-1:0] learn_rdata;
  logic              gen_req = 1'b0;
  logic [ADDR_W-1:0] gen_addr = '0;
  logic              gen_gnt, gen_rvalid;
  logic [DATA_W-1:0] gen_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              lock_err;

  logic [DATA_W-1:0] ram [64];
  logic [DATA_W-1:0] lq[$];
  logic [DATA_W-1:0] gq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  markov_table_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .learn_req   (learn_req),
    .learn_we    (learn_we),
    .learn_lock  (learn_lock),
    .learn_addr  (learn_addr),
    .learn_wdata (learn_wdata),
    .learn_gnt   (learn_gnt),
    .learn_rvalid(learn_rvalid),
    .learn_rdata (learn_rdata),
    .gen_req     (gen_req),
    .gen_addr    (gen_addr),
    .gen_gnt     (gen_gnt),
    .gen_rvalid  (gen_rvalid),
    .gen_rdata   (gen_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .lock_err    (lock_err)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid pops the oldest expected word.
  always @(negedge clk) begin
    if (learn_rvalid) begin
      if (lq.size() == 0) chk("learn_rvalid_spurious", learn_rvalid, 0);
      else                chk("learn_rdata", learn_rdata, lq.pop_front());
    end
    if (gen_rvalid) begin
      if (gq.size() == 0) chk("gen_rvalid_spurious", gen_rvalid, 0);
      else                chk("gen_rdata", gen_rdata, gq.pop_front());
    end
  end

  task automatic drive(input logic lr, input logic lwe, input logic llk,
                       input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] lwd,
                       input logic gr, input logic [ADDR_W-1:0] ga);
    @(negedge clk);
    learn_req = lr; learn_we = lwe; learn_lock = llk;
    learn_addr = la; learn_wdata = lwd;
    gen_req = gr; gen_addr = ga;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    learn_req = 1'b1; gen_req = 1'b1; learn_we = 1'b1; learn_lock = 1'b0;
    #1;
    chk("rst_learn_gnt", learn_gnt, 0);
    chk("rst_gen_gnt", gen_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    learn_req = 1'b0; gen_req = 1'b0; learn_we = 1'b0;
    #1;
    chk("rst_learn_rvalid", learn_rvalid, 0);
    chk("rst_gen_rvalid", gen_rvalid, 0);
    chk("rst_lock_err", lock_err, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[5]  = 16'h0003;
    ram[9]  = 16'h0001;
    ram[10] = 16'h00A0;

    do_reset();

    // Single learner read at address 5.
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("t1_learn_gnt", learn_gnt, 1);
    chk("t1_gen_gnt", gen_gnt, 0);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 5);
    chk("t1_mem_we", mem_we, 0);
    lq.push_back(16'h0003);
    idle();
    chk("t1_learn_rvalid", learn_rvalid, 1);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);

    // Continuous contention alternates L, G, L, G starting from the learner.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 5, 0, 1, 10);
      chk("t2_learn_gnt", learn_gnt, (i % 2 == 0));
      chk("t2_gen_gnt", gen_gnt, (i % 2 == 1));
      chk("t2_mem_addr", mem_addr, (i % 2 == 0) ? 5 : 10);
      chk("t2_gen_rvalid", gen_rvalid, (i == 2));
      if (i % 2 == 0) lq.push_back(16'h0003);
      else            gq.push_back(16'h00A0);
    end
    idle();
    chk("t2_gen_rvalid_last", gen_rvalid, 1);

    // Locked read-increment-write at address 9 with the generator waiting.
    do_reset();
    drive(1, 0, 1, 9, 0, 1, 10);
    chk("t3_lock_gnt", learn_gnt, 1);
    chk("t3_lock_gen_gnt", gen_gnt, 0);
    lq.push_back(16'h0001);
    drive(0, 0, 0, 0, 0, 1, 10);
    chk("t3_held_gen_gnt", gen_gnt, 0);
    chk("t3_held_mem_en", mem_en, 0);
    drive(1, 1, 0, 9, 16'h0004, 1, 10);
    chk("t3_wr_learn_gnt", learn_gnt, 1);
    chk("t3_wr_gen_gnt", gen_gnt, 0);
    chk("t3_wr_mem_we", mem_we, 1);
    drive(0, 0, 0, 0, 0, 1, 10);
    chk("t3_after_gen_gnt", gen_gnt, 1);
    gq.push_back(16'h00A0);
    idle();
    chk("t3_ram9", ram[9], 16'h0004);

    // Idle lock times out after LOCK_MAX cycles.
    do_reset();
    drive(1, 0, 1, 9, 0, 1, 10);
    chk("t4_lock_gnt", learn_gnt, 1);
    lq.push_back(16'h0004);
    for (int k = 1; k <= LOCK_MAX; k++) begin
      drive(0, 0, 0, 0, 0, 1, 10);
      chk("t4_lock_err", lock_err, (k == LOCK_MAX));
      chk("t4_gen_gnt_wait", gen_gnt, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 10);
    chk("t4_gen_gnt_release", gen_gnt, 1);
    chk("t4_lock_err_once", lock_err, 0);
    gq.push_back(16'h00A0);
    idle();

    // Reset right after a generator grant.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 10);
    chk("t5_gen_gnt", gen_gnt, 1);
    gq.push_back(16'h00A0);
    @(negedge clk);
    reset = 1'b1; gen_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    learn_req = 1'b1; learn_we = 1'b0; learn_lock = 1'b0; learn_addr = 5;
    gen_req = 1'b1; gen_addr = 10;
    #1;
    chk("t5_gen_rvalid_dropped", gen_rvalid, 0);
    chk("t5_learn_first", learn_gnt, 1);
    chk("t5_gen_not_first", gen_gnt, 0);
    lq.push_back(16'h0003);
    idle();

    // Write at top address produces no read return.
    drive(1, 1, 0, 63, 16'hFFFF, 0, 0);
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_addr", mem_addr, 63);
    chk("t6_mem_wdata", mem_wdata, 16'hFFFF);
    idle();
    chk("t6_no_rvalid", learn_rvalid, 0);
    chk("t6_ram63", ram[63], 16'hFFFF);

    idle();
    idle();
    chk("learn_queue_empty", lq.size(), 0);
    chk("gen_queue_empty", gq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
